// File: rtl/fc_layer_tiled_ctrl.sv
// Tiled fully-connected layer sequencer.
// Runs NUM_PASSES CIM passes (load ibuf addresses, start MVM, drain obuf),
// accumulates signed partial sums across passes, then requantises the
// accumulators and streams them to the next layer under valid/ready.
// Optional macro FC_SIGNED_OUT_EN: signed saturated output instead of
// unsigned ReLU + saturation.
module fc_layer_tiled_ctrl #(
  parameter int DATA_SIZE     = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int PSUM_WIDTH    = 25,
  parameter int ACC_WIDTH     = 30,
  parameter int NUM_ADDR      = 32,
  parameter int NUM_ADDR_OBUF = 16,
  parameter int NUM_PASSES    = 4,
  parameter int SHIFT         = 10,
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1,
  localparam int ADDR_W = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
  localparam int OBUF_W = (NUM_ADDR_OBUF > 1) ? $clog2(NUM_ADDR_OBUF) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  output logic                               o_ready,
  output logic [PASS_W-1:0]                  o_pass,
  output logic [ADDR_W-1:0]                  o_cim_addr,
  output logic                               o_cim_we,
  output logic                               o_cim_start,
  input  logic                               i_cim_ready,
  output logic [OBUF_W-1:0]                  o_obuf_addr,
  input  logic [NUM_CHANNELS*PSUM_WIDTH-1:0] i_obuf_data,
  input  logic                               i_next_ready,
  output logic [NUM_CHANNELS*DATA_SIZE-1:0]  o_next_data,
  output logic                               o_next_we,
  output logic                               o_next_start
);

  // The drain counter needs one extra count for the trailing read-latency cycle.
  localparam int DRAIN_W = $clog2(NUM_ADDR_OBUF + 1);

`ifdef FC_SIGNED_OUT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((2 ** (DATA_SIZE - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-(2 ** (DATA_SIZE - 1)));
`else
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((2 ** DATA_SIZE) - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [PASS_W-1:0]  pass_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DRAIN_W-1:0] drain_q;
  logic [OBUF_W-1:0]  out_idx_q;

  logic signed [ACC_WIDTH-1:0] acc      [NUM_ADDR_OBUF][NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0] psum_ext [NUM_CHANNELS];

  logic [OBUF_W-1:0]                 wr_idx;
  logic [OBUF_W-1:0]                 rd_idx;
  logic [NUM_CHANNELS*DATA_SIZE-1:0] rq_word;

  logic load_last, drain_last, last_pass, out_xfer, out_last;

  assign load_last  = (addr_q == ADDR_W'(NUM_ADDR - 1));
  assign drain_last = (drain_q == DRAIN_W'(NUM_ADDR_OBUF));
  assign last_pass  = (pass_q == PASS_W'(NUM_PASSES - 1));
  assign out_xfer   = o_next_we & i_next_ready;
  assign out_last   = (out_idx_q == OBUF_W'(NUM_ADDR_OBUF - 1));

  // Shift, then clip/saturate one accumulator to an activation.
  function automatic logic [DATA_SIZE-1:0] requant(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] v;
    v = a >>> SHIFT;
`ifdef FC_SIGNED_OUT_EN
    if (v > SAT_HI)      return SAT_HI[DATA_SIZE-1:0];
    else if (v < SAT_LO) return SAT_LO[DATA_SIZE-1:0];
    else                 return v[DATA_SIZE-1:0];
`else
    if (v[ACC_WIDTH-1])  return '0;
    else if (v > SAT_HI) return '1;
    else                 return v[DATA_SIZE-1:0];
`endif
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      S_IDLE:   if (i_start) next_state = S_LOAD;
      S_LOAD:   if (load_last) next_state = S_START;
      S_START:  next_state = S_WAIT;
      // The START cycle's ready is never looked at; WAIT always lasts at
      // least one cycle, so a ready that never dropped is not trusted early.
      S_WAIT:   if (i_cim_ready) next_state = S_DRAIN;
      S_DRAIN:  if (drain_last) next_state = last_pass ? S_OUTPUT : S_LOAD;
      S_OUTPUT: if (out_xfer && out_last) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  assign o_ready      = (state == S_IDLE);
  assign o_cim_we     = (state == S_LOAD);
  assign o_cim_start  = (state == S_START);
  assign o_next_start = (state == S_DONE);
  assign o_pass       = pass_q;
  assign o_cim_addr   = addr_q;
  // drain_q == NUM_ADDR_OBUF (latency cycle) truncates to address 0.
  assign o_obuf_addr  = OBUF_W'(drain_q);

  // Sign-extend each channel's partial sum and pick read/write rows.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      psum_ext[c] = ACC_WIDTH'(signed'(i_obuf_data[c*PSUM_WIDTH +: PSUM_WIDTH]));
    end
    wr_idx  = OBUF_W'(drain_q - DRAIN_W'(1));
    rd_idx  = (state == S_OUTPUT) ? out_idx_q + OBUF_W'(1) : '0;
    rq_word = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rq_word[c*DATA_SIZE +: DATA_SIZE] = requant(acc[rd_idx][c]);
    end
  end

  // Accumulator array: pass 0 overwrites, later passes add.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; pass 0 always overwrites every entry,
    // so its power-up contents never reach the output.
    if (rst && state == S_DRAIN && drain_q != '0) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        acc[wr_idx][c] <= (pass_q == '0) ? psum_ext[c] : acc[wr_idx][c] + psum_ext[c];
      end
    end
  end

  // Counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pass_q      <= '0;
      addr_q      <= '0;
      drain_q     <= '0;
      out_idx_q   <= '0;
      o_next_we   <= 1'b0;
      o_next_data <= '0;
    end else begin
      unique case (state)
        S_LOAD: addr_q <= load_last ? '0 : addr_q + ADDR_W'(1);
        S_DRAIN: begin
          if (drain_last) begin
            drain_q <= '0;
            if (last_pass) begin
              o_next_we   <= 1'b1;
              o_next_data <= rq_word;
              out_idx_q   <= '0;
            end else begin
              pass_q <= pass_q + PASS_W'(1);
            end
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        S_OUTPUT: begin
          if (out_xfer) begin
            if (out_last) begin
              o_next_we <= 1'b0;
            end else begin
              out_idx_q   <= out_idx_q + OBUF_W'(1);
              o_next_data <= rq_word;
            end
          end
        end
        S_DONE:  pass_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_tiled_ctrl.sv
// Self-checking bench for fc_layer_tiled_ctrl: a 4-pass instance driven by a
// per-word partial-sum table with hand-computed results, and a 1-pass instance.
module tb_fc_layer_tiled_ctrl;
  localparam int NC = 2;
  localparam int PW = 25;
  localparam int NA = 32;
  localparam int NO = 16;
  localparam int NP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          start4, cim_ready4, next_ready4;
  logic [NC*PW-1:0] obuf4;
  logic          ready4, cim_we4, cim_start4, next_we4, next_start4;
  logic [1:0]    pass4;
  logic [4:0]    cim_addr4;
  logic [3:0]    obuf_addr4;
  logic [15:0]   next_data4;

  logic          start1, cim_ready1, next_ready1;
  logic [NC*PW-1:0] obuf1;
  logic          ready1, cim_we1, cim_start1, next_we1, next_start1;
  logic [0:0]    pass1;
  logic [4:0]    cim_addr1;
  logic [3:0]    obuf_addr1;
  logic [15:0]   next_data1;

  fc_layer_tiled_ctrl #(.NUM_PASSES(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(start4), .o_ready(ready4), .o_pass(pass4),
    .o_cim_addr(cim_addr4), .o_cim_we(cim_we4), .o_cim_start(cim_start4),
    .i_cim_ready(cim_ready4), .o_obuf_addr(obuf_addr4), .i_obuf_data(obuf4),
    .i_next_ready(next_ready4), .o_next_data(next_data4), .o_next_we(next_we4),
    .o_next_start(next_start4)
  );

  fc_layer_tiled_ctrl #(.NUM_PASSES(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .o_ready(ready1), .o_pass(pass1),
    .o_cim_addr(cim_addr1), .o_cim_we(cim_we1), .o_cim_start(cim_start1),
    .i_cim_ready(cim_ready1), .o_obuf_addr(obuf_addr1), .i_obuf_data(obuf1),
    .i_next_ready(next_ready1), .o_next_data(next_data1), .o_next_we(next_we1),
    .o_next_start(next_start1)
  );

  // Per obuf word: channel-0 psums per pass (a*), channel-1 psums (b*),
  // expected unsigned (eu*) and signed (es*) activations.
  typedef struct {
    int a0, a1, a2, a3;
    int b0, b1, b2, b3;
    int eu0, eu1, es0, es1;
  } vec_t;
  vec_t vecs [NO];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int psum_of(input int p, input int a, input int c);
    vec_t v;
    v = vecs[a];
    case (p)
      0:       return (c == 0) ? v.a0 : v.b0;
      1:       return (c == 0) ? v.a1 : v.b1;
      2:       return (c == 0) ? v.a2 : v.b2;
      default: return (c == 0) ? v.a3 : v.b3;
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input int k);
    vec_t v;
    v = vecs[k];
`ifdef FC_SIGNED_OUT_EN
    return {8'(v.es1), 8'(v.es0)};
`else
    return {8'(v.eu1), 8'(v.eu0)};
`endif
  endfunction

  // Output-buffer model for the 4-pass instance: one-cycle read latency.
  always @(negedge clk) begin : obuf_model
    int a, p;
    a = int'(obuf_addr4);
    p = int'(pass4);
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) obuf4[c*PW +: PW] = PW'(psum_of(p, a, c));
  end

  // One full inference on the 4-pass instance, checking every phase.
  task automatic run4(input int stall_word, input int stall_len, input bit hold_ready);
    int cyc = 0, we_cnt = 0, st_cnt = 0, xfer = 0, cd = 0, st_cyc = -100, fw = -1;
    int stall_left;
    bit done = 1'b0;
    stall_left  = stall_len;
    cim_ready4  = 1'b1;
    next_ready4 = 1'b1;
    start4      = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start4 = 1'b0;
      if (cyc == 1) check("ready_drop", ready4, 0);
      if (cim_we4) begin
        check("cim_addr", cim_addr4, we_cnt % NA);
        check("load_pass", pass4, we_cnt / NA);
        we_cnt++;
      end
      if (cim_start4) begin
        check("load_len", we_cnt, NA * (st_cnt + 1));
        check("start_pass", pass4, st_cnt);
        st_cnt++;
        st_cyc = cyc;
        if (!hold_ready) begin
          cim_ready4 = 1'b0;
          cd = 3;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) cim_ready4 = 1'b1;
      end
      if (hold_ready) begin
        if (cyc == st_cyc + 3)  check("drain_entry", obuf_addr4, 1);
        if (cyc == st_cyc + 17) check("drain_last_addr", obuf_addr4, NO - 1);
        start4 = (obuf_addr4 != 0);
      end
      if (next_we4) begin
        if (fw < 0) fw = cyc;
        if (xfer >= NO) check("extra_word", xfer, NO - 1);
        else            check("out_word", next_data4, exp_word(xfer));
        if (xfer == stall_word && stall_left > 0) begin
          next_ready4 = 1'b0;
          stall_left--;
        end else begin
          next_ready4 = 1'b1;
          xfer++;
        end
      end else begin
        next_ready4 = 1'b1;
      end
      if (next_start4) begin
        check("xfer_cnt", xfer, NO);
        check("cim_start_cnt", st_cnt, NP);
        check("cim_we_cnt", we_cnt, NP * NA);
        check("out_cycles", cyc - fw, NO + stall_len);
        done = 1'b1;
      end
    end
    check("run_done", done, 1);
    start4 = 1'b0;
    @(negedge clk);
    check("next_start_pulse", next_start4, 0);
    check("ready_after", ready4, 1);
    check("pass_after", pass4, 0);
  endtask

  // Start an inference and pull reset mid-flight (DRAIN of pass 2 or OUTPUT).
  task automatic abort4(input bit in_output);
    int cyc = 0;
    bit hit = 1'b0;
    cim_ready4  = 1'b1;
    next_ready4 = 1'b1;
    start4      = 1'b1;
    while (!hit && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start4 = 1'b0;
      if (in_output ? next_we4 : (pass4 == 2'd2 && obuf_addr4 == 4'd5)) hit = 1'b1;
    end
    check("abort_reach", hit, 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", ready4, 1);
    check("abort_cim_we", cim_we4, 0);
    check("abort_next_we", next_we4, 0);
    check("abort_pass", pass4, 0);
    check("abort_obuf_addr", obuf_addr4, 0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_next_start", next_start4, 0);
    end
  endtask

  // Single-pass instance: all psums 2048 -> every activation 2.
  task automatic run1();
    int cyc = 0, we = 0, st = 0, words = 0;
    bit done = 1'b0;
    start1 = 1'b1;
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
      start1 = 1'b0;
      if (cim_we1) begin
        check("p1_addr", cim_addr1, we);
        we++;
      end
      if (cim_start1) begin
        st++;
        check("p1_load_len", we, NA);
      end
      if (next_we1) begin
        check("p1_word", next_data1, 16'h0202);
        words++;
      end
      if (next_start1) begin
        check("p1_words", words, NO);
        check("p1_starts", st, 1);
        done = 1'b1;
      end
    end
    check("p1_done", done, 1);
    @(negedge clk);
    check("p1_pulse", next_start1, 0);
    check("p1_ready", ready1, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1000, 1000, 1000, 1000,  2048, 2048, 2048, 2048,  3, 8, 3, 8};
    vecs[1]  = '{262144, 262144, 262144, 262144,  -1250, -1250, -1250, -1250,  255, 0, 127, -5};
    vecs[2]  = '{0, 0, 0, 0,  1023, 1023, 1023, 1023,  0, 3, 0, 3};
    vecs[3]  = '{261120, 0, 0, 0,  0, 0, 0, 1024,  255, 1, 127, 1};
    vecs[4]  = '{262143, 1, 0, 0,  -1, -1, -1, -1,  255, 0, 127, -1};
    vecs[5]  = '{130048, 0, 0, 0,  -131072, 0, 0, 0,  127, 0, 127, -128};
    vecs[6]  = '{-132096, 0, 0, 0,  131071, 0, 0, 0,  0, 127, -128, 127};
    vecs[7]  = '{5000, -3000, 2000, -1000,  -2000, 3000, 1000, 500,  2, 2, 2, 2};
    vecs[8]  = '{1024, 1024, 1024, 1024,  16777215, 16777215, 16777215, 16777215,  4, 255, 4, 127};
    vecs[9]  = '{-16777216, -16777216, -16777216, -16777216,  0, 0, 7168, 0,  0, 7, -128, 7};
    vecs[10] = '{256, 256, 256, 256,  255, 255, 255, 255,  1, 0, 1, 0};
    vecs[11] = '{25600, 25600, 25600, 25600,  -256, -256, -256, -256,  100, 0, 100, -1};
    vecs[12] = '{51200, 51200, 51200, 51200,  -1024, 1024, 0, 0,  200, 0, 127, 0};
    vecs[13] = '{3, 3, 3, 3,  65536, 65536, 65536, 65536,  0, 255, 0, 127};
    vecs[14] = '{-1, 0, 0, 0,  10000, 0, 0, 0,  0, 9, -1, 9};
    vecs[15] = '{32768, 32768, 32768, 32768,  0, 0, 0, 40000,  128, 39, 127, 39};

    rst = 1'b0;
    start4 = 1'b0; cim_ready4 = 1'b1; next_ready4 = 1'b1; obuf4 = '0;
    start1 = 1'b0; cim_ready1 = 1'b1; next_ready1 = 1'b1;
    obuf1 = {25'd2048, 25'd2048};
    repeat (3) @(negedge clk);

    check("rst_ready", ready4, 1);
    check("rst_cim_we", cim_we4, 0);
    check("rst_cim_start", cim_start4, 0);
    check("rst_next_we", next_we4, 0);
    check("rst_next_start", next_start4, 0);
    check("rst_pass", pass4, 0);
    check("rst_cim_addr", cim_addr4, 0);
    check("rst_obuf_addr", obuf_addr4, 0);
    check("rst_next_data", next_data4, 0);
    check("rst_ready1", ready1, 1);
    rst = 1'b1;
    @(negedge clk);

    run1();
    run4(-1, 0, 1'b0);
    run4(3, 5, 1'b0);
    run4(-1, 0, 1'b1);
    abort4(1'b0);
    run4(-1, 0, 1'b0);
    abort4(1'b1);
    run4(-1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_layer_tiled_ctrl.md
Name: fc_layer_tiled_ctrl

Overview:
Next-generation FC layer sequencer for layers whose input vector exceeds one crossbar column height.
- Runs NUM_PASSES CIM passes; per pass it streams input-buffer addresses to the tiles, starts the MVM and drains the tile output buffer.
- Accumulates signed partial sums across passes in an internal accumulator array.
- Requantises (shift, clip, saturate) and streams results to the next layer under a stall-capable handshake.

Parameters:
DATA_SIZE, 8, activation width delivered to next layer
NUM_CHANNELS, 2, obuf elements read per address
PSUM_WIDTH, 25, signed width of one CIM partial sum
ACC_WIDTH, 30, signed accumulator width (>= PSUM_WIDTH + clog2(NUM_PASSES))
NUM_ADDR, 32, ibuf addresses streamed per pass
NUM_ADDR_OBUF, 16, obuf addresses drained per pass
NUM_PASSES, 4, input tiling passes per inference (>= 1)
SHIFT, 10, arithmetic right shift applied at requantisation

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
i_start  input  1  ibuf filled, begin inference (sampled in IDLE only)
o_ready  output  1  idle, ibuf may be written
o_pass  output  clog2(NUM_PASSES)  current pass index (selects ibuf bank)
o_cim_addr  output  clog2(NUM_ADDR)  ibuf read / CIM input address
o_cim_we  output  1  CIM input write strobe
o_cim_start  output  1  one-cycle MVM start pulse
i_cim_ready  input  1  CIM tiles idle/done
o_obuf_addr  output  clog2(NUM_ADDR_OBUF)  CIM output-buffer read address
i_obuf_data  input  NUM_CHANNELS*PSUM_WIDTH  signed partial sums, channel c at [c*PSUM_WIDTH +: PSUM_WIDTH]
i_next_ready  input  1  next layer accepts data
o_next_data  output  NUM_CHANNELS*DATA_SIZE  requantised activations
o_next_we  output  1  o_next_data valid
o_next_start  output  1  one-cycle pulse: layer output complete

Behaviour:
- Reset (rst=0 at posedge): state IDLE, o_ready=1, all other outputs 0, pass counter 0. Accumulator contents are don't-care; pass 0 overwrites them.
- IDLE: o_ready=1. i_start=1 -> LOAD, o_ready=0 next cycle.
- LOAD: o_cim_we=1 for exactly NUM_ADDR consecutive cycles, o_cim_addr 0..NUM_ADDR-1. Last address -> START.
- START: o_cim_start=1 for one cycle -> WAIT.
- WAIT: the cycle after START is ignored (tiles deassert ready). Thereafter i_cim_ready=1 -> DRAIN.
- DRAIN: o_obuf_addr steps 0..NUM_ADDR_OBUF-1, one per cycle. Read latency is 1: data for addr k arrives the cycle after k is presented.
  - Pass 0: acc[k][c] = sext(psum).
  - Passes >0: acc[k][c] += sext(psum).
  - After the last word lands: if pass < NUM_PASSES-1, increment pass -> LOAD; else -> OUTPUT.
  - Total DRAIN occupancy is NUM_ADDR_OBUF+1 cycles.
- OUTPUT: for k = 0..NUM_ADDR_OBUF-1, per channel compute v = acc >>> SHIFT (arithmetic).
  - Without the optional feature: negative v -> 0; v > 2^DATA_SIZE-1 -> 2^DATA_SIZE-1.
  - Output is registered: o_next_we=1 with data.
  - i_next_ready=0 holds o_next_we, data and k unchanged (stall). A word transfers only on a cycle with o_next_we & i_next_ready.
  - After the last transfer: o_next_start=1 for one cycle, pass counter reset to 0 -> IDLE.
- Throughput: zero-stall output completes in NUM_ADDR_OBUF cycles.
- Boundaries:
  - i_start while busy: ignored.
  - i_cim_ready already high in WAIT: still waits the mandatory one cycle.
  - NUM_PASSES=1: no accumulation; the overwrite path feeds OUTPUT directly.
  - rst=0 mid-operation: immediate return to IDLE, any in-flight o_cim_we/o_next_we dropped next cycle, no o_next_start.
- Accumulation does not wrap, because ACC_WIDTH is sized per its parameter rule.

Optional Feature:
FC_SIGNED_OUT_EN
- Defined: output is signed two's-complement. v saturates to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1]; no ReLU clip.
- Undefined: unsigned ReLU + saturation as in Behaviour.

Test Plan:
1. Reset then i_start with NUM_PASSES=1, all psums = 2048 (SHIFT=10) -> NUM_ADDR we pulses with addr 0..31, one o_cim_start, 16 output words all channels = 2, then o_next_start one cycle.
2. NUM_PASSES=4, psum per pass = 1000 -> acc 4000 -> output 3. o_pass sequence 0,1,2,3; four o_cim_start pulses.
3. Saturation/clip: acc = 2^20 -> 255; acc = -5000 -> 0. With FC_SIGNED_OUT_EN: 127 and -5.
4. Stall: i_next_ready low for 5 cycles at word 3 -> word 3 held stable, no duplication or loss, 16 transfers total.
5. i_cim_ready held high throughout -> DRAIN entered exactly 2 cycles after the o_cim_start cycle. i_start asserted during DRAIN -> ignored.
6. rst=0 during DRAIN of pass 2 -> o_ready=1 next cycle. A new i_start then yields correct pass-0 overwrite results (no stale accumulation).
